// File: rtl/vga_sync_param.sv
// Parameterised VGA timing generator.
// Free-running pixel and line counters advance on pix_ce. They drive sync, video-enable and
// first-pixel flags through one register plus SYNC_DLY pix_ce-qualified delay stages.
// Optional macro ADV7123_EN adds the ADV7123 DAC control outputs.
module vga_sync_param #(
   parameter int unsigned HVA      = 640,
   parameter int unsigned HFP      = 16,
   parameter int unsigned HSW      = 96,
   parameter int unsigned HBP      = 48,
   parameter int unsigned VVA      = 480,
   parameter int unsigned VFP      = 10,
   parameter int unsigned VSW      = 2,
   parameter int unsigned VBP      = 33,
   parameter int unsigned HPOL     = 0,
   parameter int unsigned VPOL     = 0,
   parameter int unsigned SYNC_DLY = 2,
   localparam int unsigned HTOT    = HVA + HFP + HSW + HBP,
   localparam int unsigned VTOT    = VVA + VFP + VSW + VBP,
   localparam int unsigned XW      = $clog2(HTOT),
   localparam int unsigned YW      = $clog2(VTOT)
) (
   input  logic          clk_vga,
   input  logic          rst_vga_n,
   input  logic          pix_ce,
   output logic [XW-1:0] pix_x,
   output logic [YW-1:0] pix_y,
   output logic          vga_hsync,
   output logic          vga_vsync,
   output logic          vga_video_on,
   output logic          first_pixel,
`ifdef ADV7123_EN
   output logic          adv7123_vga_blank,
   output logic          adv7123_vga_sync,
   output logic          adv7123_vga_clk,
`endif
   output logic          line_start
);

   localparam logic          HACT     = (HPOL != 0);
   localparam logic          VACT     = (VPOL != 0);
   localparam logic [XW-1:0] HMAX     = XW'(HTOT - 1);
   localparam logic [YW-1:0] VMAX     = YW'(VTOT - 1);
   localparam logic [XW-1:0] HVA_C    = XW'(HVA);
   localparam logic [YW-1:0] VVA_C    = YW'(VVA);
   localparam logic [XW-1:0] HS_START = XW'(HVA + HFP);
   localparam logic [XW-1:0] HS_END   = XW'(HVA + HFP + HSW);
   localparam logic [YW-1:0] VS_START = YW'(VVA + VFP);
   localparam logic [YW-1:0] VS_END   = YW'(VVA + VFP + VSW);
   // Stage layout: {hsync, vsync, video_on, first_pixel}; reset holds every stage inactive.
   localparam logic [3:0]    RST_VEC  = {~HACT, ~VACT, 1'b0, 1'b0};

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [3:0]    raw;
   logic [3:0]    pipe_q [0:SYNC_DLY];
   logic          fp_dly;

   // Next-state for the counters: x wraps at HTOT-1, y steps only on the x wrap.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (pix_ce) begin
         if (x_q == HMAX) begin
            x_d = '0;
            y_d = (y_q == VMAX) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // Counter state registers.
   always_ff @(posedge clk_vga or negedge rst_vga_n) begin
      if (!rst_vga_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   // Undelayed timing flags decoded from the current counter values.
   always_comb begin
      raw    = RST_VEC;
      raw[3] = (x_q >= HS_START && x_q < HS_END) ? HACT : ~HACT;
      raw[2] = (y_q >= VS_START && y_q < VS_END) ? VACT : ~VACT;
      raw[1] = (x_q < HVA_C) && (y_q < VVA_C);
      raw[0] = (x_q == '0) && (y_q == '0) && pix_ce;
   end

   // Output register plus SYNC_DLY delay stages, all frozen while pix_ce is low.
   always_ff @(posedge clk_vga or negedge rst_vga_n) begin
      if (!rst_vga_n) begin
         for (int unsigned i = 0; i <= SYNC_DLY; i++) pipe_q[i] <= RST_VEC;
      end else if (pix_ce) begin
         pipe_q[0] <= raw;
         for (int unsigned i = 1; i <= SYNC_DLY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign pix_x = x_q;
   assign pix_y = y_q;
   assign {vga_hsync, vga_vsync, vga_video_on, fp_dly} = pipe_q[SYNC_DLY];
   // The held first-pixel stage is only shown on a cycle that actually advances the timing.
   assign first_pixel = fp_dly & pix_ce;
   assign line_start  = (x_q == '0) & pix_ce;

`ifdef ADV7123_EN
   assign adv7123_vga_blank = vga_video_on;
   assign adv7123_vga_sync  = 1'b0;
   assign adv7123_vga_clk   = ~clk_vga;
`endif

endmodule

// File: tb/tb_vga_sync_param.sv
// Bench for vga_sync_param: two small-geometry instances (12 x 7 frame) sharing stimulus.
// Instance A: HPOL=1, VPOL=0, SYNC_DLY=0.  Instance B: HPOL=0, VPOL=1, SYNC_DLY=2.
module tb_vga_sync_param;

   logic       clk_vga = 1'b0;
   logic       rst_vga_n = 1'b0;
   logic       pix_ce = 1'b0;
   logic [3:0] x_a, x_b;
   logic [2:0] y_a, y_b;
   logic       hs_a, vs_a, vid_a, fp_a, ls_a;
   logic       hs_b, vs_b, vid_b, fp_b, ls_b;
`ifdef ADV7123_EN
   logic       blank_a, sync_a, dclk_a, blank_b, sync_b, dclk_b;
`endif

   int n_pass = 0;
   int n_total = 0;
   int n = 0;

   always #5 clk_vga = ~clk_vga;

   vga_sync_param #(
      .HVA(8), .HFP(1), .HSW(2), .HBP(1), .VVA(4), .VFP(1), .VSW(1), .VBP(1),
      .HPOL(1), .VPOL(0), .SYNC_DLY(0)
   ) u_dut_a (
      .clk_vga(clk_vga), .rst_vga_n(rst_vga_n), .pix_ce(pix_ce),
      .pix_x(x_a), .pix_y(y_a), .vga_hsync(hs_a), .vga_vsync(vs_a),
      .vga_video_on(vid_a), .first_pixel(fp_a),
`ifdef ADV7123_EN
      .adv7123_vga_blank(blank_a), .adv7123_vga_sync(sync_a), .adv7123_vga_clk(dclk_a),
`endif
      .line_start(ls_a)
   );

   vga_sync_param #(
      .HVA(8), .HFP(1), .HSW(2), .HBP(1), .VVA(4), .VFP(1), .VSW(1), .VBP(1),
      .HPOL(0), .VPOL(1), .SYNC_DLY(2)
   ) u_dut_b (
      .clk_vga(clk_vga), .rst_vga_n(rst_vga_n), .pix_ce(pix_ce),
      .pix_x(x_b), .pix_y(y_b), .vga_hsync(hs_b), .vga_vsync(vs_b),
      .vga_video_on(vid_b), .first_pixel(fp_b),
`ifdef ADV7123_EN
      .adv7123_vga_blank(blank_b), .adv7123_vga_sync(sync_b), .adv7123_vga_clk(dclk_b),
`endif
      .line_start(ls_b)
   );

   typedef struct {
      int         n;
      logic [3:0] x;
      logic [2:0] y;
      logic       hs_a, vs_a, vid_a, fp_a;
      logic       hs_b, vs_b, vid_b, fp_b;
      logic       ls;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int idx, input logic [7:0] act,
                        input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
   endtask

   // Advance (with pix_ce=1) until t enabled edges have occurred since reset, then sample.
   task automatic advance_to(input int t);
      while (n < t) begin
         @(posedge clk_vga);
         n++;
      end
      #1;
   endtask

   initial begin
      // n, x, y, hsA, vsA, vidA, fpA, hsB, vsB, vidB, fpB, line_start
      vecs.push_back('{0,  0,  0, 0, 1, 0, 0, 1, 0, 0, 0, 1});
      vecs.push_back('{1,  1,  0, 0, 1, 1, 1, 1, 0, 0, 0, 0});
      vecs.push_back('{3,  3,  0, 0, 1, 1, 0, 1, 0, 1, 1, 0});
      vecs.push_back('{4,  4,  0, 0, 1, 1, 0, 1, 0, 1, 0, 0});
      vecs.push_back('{8,  8,  0, 0, 1, 1, 0, 1, 0, 1, 0, 0});
      vecs.push_back('{9,  9,  0, 0, 1, 0, 0, 1, 0, 1, 0, 0});
      vecs.push_back('{10, 10, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0});
      vecs.push_back('{11, 11, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0});
      vecs.push_back('{12, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{13, 1,  1, 0, 1, 1, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{14, 2,  1, 0, 1, 1, 0, 1, 0, 0, 0, 0});
      vecs.push_back('{15, 3,  1, 0, 1, 1, 0, 1, 0, 1, 0, 0});
      vecs.push_back('{49, 1,  4, 0, 1, 0, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{61, 1,  5, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{63, 3,  5, 0, 0, 0, 0, 1, 1, 0, 0, 0});
      vecs.push_back('{72, 0,  6, 0, 0, 0, 0, 0, 1, 0, 0, 1});
      vecs.push_back('{73, 1,  6, 0, 1, 0, 0, 0, 1, 0, 0, 0});
      vecs.push_back('{83, 11, 6, 1, 1, 0, 0, 1, 0, 0, 0, 0});
      vecs.push_back('{84, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{85, 1,  0, 0, 1, 1, 1, 0, 0, 0, 0, 0});
      vecs.push_back('{87, 3,  0, 0, 1, 1, 0, 1, 0, 1, 1, 0});

      // Reset with pix_ce high, release away from the active edge.
      pix_ce = 1'b1;
      repeat (3) @(negedge clk_vga);
      rst_vga_n = 1'b1;
      n = 0;

      foreach (vecs[i]) begin
         advance_to(vecs[i].n);
         check("pix_x_a", vecs[i].n, 8'(x_a), 8'(vecs[i].x));
         check("pix_y_a", vecs[i].n, 8'(y_a), 8'(vecs[i].y));
         check("pix_x_b", vecs[i].n, 8'(x_b), 8'(vecs[i].x));
         check("hsync_a", vecs[i].n, 8'(hs_a), 8'(vecs[i].hs_a));
         check("vsync_a", vecs[i].n, 8'(vs_a), 8'(vecs[i].vs_a));
         check("video_a", vecs[i].n, 8'(vid_a), 8'(vecs[i].vid_a));
         check("first_a", vecs[i].n, 8'(fp_a), 8'(vecs[i].fp_a));
         check("hsync_b", vecs[i].n, 8'(hs_b), 8'(vecs[i].hs_b));
         check("vsync_b", vecs[i].n, 8'(vs_b), 8'(vecs[i].vs_b));
         check("video_b", vecs[i].n, 8'(vid_b), 8'(vecs[i].vid_b));
         check("first_b", vecs[i].n, 8'(fp_b), 8'(vecs[i].fp_b));
         check("lstart_a", vecs[i].n, 8'(ls_a), 8'(vecs[i].ls));
`ifdef ADV7123_EN
         check("adv_blank", vecs[i].n, 8'(blank_a), 8'(vecs[i].vid_a));
         check("adv_sync", vecs[i].n, 8'(sync_b), 8'h00);
         check("adv_clk", vecs[i].n, 8'(dclk_a), 8'(~clk_vga));
`endif
      end

      // pix_ce low: everything holds at (3,0); B's pending first_pixel is hidden, not lost.
      @(negedge clk_vga);
      pix_ce = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk_vga);
         #1;
         check("hold_x", k, 8'(x_a), 8'd3);
         check("hold_vid_b", k, 8'(vid_b), 8'd1);
         check("hold_hs_b", k, 8'(hs_b), 8'd1);
         check("hold_fp_b", k, 8'(fp_b), 8'd0);
         check("hold_ls", k, 8'(ls_a), 8'd0);
      end
      @(negedge clk_vga);
      pix_ce = 1'b1;
      #1;
      check("ce_fp_b", 0, 8'(fp_b), 8'd1);
      advance_to(88);
      check("ce_x", 88, 8'(x_a), 8'd4);
      check("ce_fp_b_after", 88, 8'(fp_b), 8'd0);

      // Mid-frame async reset while B's pipeline carries an active hsync.
      advance_to(95);
      #2;
      rst_vga_n = 1'b0;
      #1;
      check("rst_x", 0, 8'(x_a), 8'd0);
      check("rst_y", 0, 8'(y_a), 8'd0);
      check("rst_hs_a", 0, 8'(hs_a), 8'd0);
      check("rst_vs_a", 0, 8'(vs_a), 8'd1);
      check("rst_hs_b", 0, 8'(hs_b), 8'd1);
      check("rst_vs_b", 0, 8'(vs_b), 8'd0);
      check("rst_vid_b", 0, 8'(vid_b), 8'd0);
      @(negedge clk_vga);
      rst_vga_n = 1'b1;
      n = 0;
      for (int t = 1; t <= 3; t++) begin
         advance_to(t);
         check("rel_x", t, 8'(x_a), 8'(t));
         check("rel_hs_b", t, 8'(hs_b), 8'd1);
         check("rel_vid_b", t, 8'(vid_b), (t == 3) ? 8'd1 : 8'd0);
         check("rel_fp_b", t, 8'(fp_b), (t == 3) ? 8'd1 : 8'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
